mig_app_responder: RTL and testbench
====================================

# mig_app_responder

Synthesizable responder for the MIG-style user application interface (app_cmd/app_en/app_rdy, app_wdf_*, app_rd_data*) driven by the team's DDR controller. It answers read and write commands from an internal on-chip memory with a fixed read latency, a calibration delay and optional randomized backpressure. It replaces the MIG core and external DDR in simulation benches and in DDR-less FPGA builds of the associative processor, so `ddr_controller` can be exercised unchanged.

## Interface
- DDR_DATA_WIDTH, 128, data beat width; mask width is DDR_DATA_WIDTH/8
- DDR_ADDR_WIDTH, 28, app_addr width
- MEM_DEPTH_LOG2, 10, log2 of stored beats
- RD_LATENCY, 4, cycles from read acceptance to app_rd_data_valid; legal range 2..16
- CALIB_CYCLES, 16, cycles from reset release to init_calib_complete; legal range 1..65535
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- app_addr  in  DDR_ADDR_WIDTH  beat address; 8 per beat, word index = app_addr[MEM_DEPTH_LOG2+2:3], higher bits ignored (wrap)
- app_cmd  in  3  3'b000 write, 3'b001 read, others illegal
- app_en  in  1  command valid
- app_rdy  out  1  command ready
- app_wdf_data  in  DDR_DATA_WIDTH  write data
- app_wdf_mask  in  DDR_DATA_WIDTH/8  byte mask, 1 = byte not written
- app_wdf_wren  in  1  write data valid
- app_wdf_end  in  1  accepted, ignored (single-beat bursts only)
- app_wdf_rdy  out  1  write data ready
- app_rd_data  out  DDR_DATA_WIDTH  read data
- app_rd_data_valid  out  1  read data strobe, one cycle per read command
- init_calib_complete  out  1  calibration done
- cmd_err  out  1  sticky: illegal app_cmd accepted

## Operation
- Reset values: app_rdy 0, app_wdf_rdy 0, app_rd_data 0, app_rd_data_valid 0, init_calib_complete 0, cmd_err 0. Reset clears FIFOs, read pipeline, calibration counter, LFSR; memory array contents are retained.
- Calibration: counter increments each cycle after reset release; init_calib_complete goes high once it reaches CALIB_CYCLES and stays high until reset. While low, app_rdy and app_wdf_rdy are 0.
- Write-address FIFO (depth 4) stores word indexes of accepted write commands; write-data FIFO (depth 4) stores data+mask of accepted beats. Data may arrive before or after its command, in order.
- Commit: when both FIFOs non-empty, pop both and write the data into the addressed word, honoring the mask per byte. One commit per cycle max.
- app_wdf_rdy = calib done and data FIFO not full.
- app_rdy = calib done and address FIFO not full and not (app_cmd == read and address FIFO non-empty). Reads therefore never overtake pending writes (read-after-write coherent).
- Command acceptance = app_en & app_rdy at an edge. Read: memory word sampled that edge and enters a RD_LATENCY-deep valid/data pipeline; one read per cycle sustained, returned in order. Illegal cmd: accepted, no memory effect, cmd_err set.
- app_rd_data holds last returned value between strobes.

## Timing
- Read accepted at edge T -> app_rd_data_valid high exactly in cycle after edge T+RD_LATENCY-1 (RD_LATENCY edges after T), data = memory content including all writes committed before T.
- Write commit occurs at the first edge where both FIFO heads are present; a write command and its data accepted at the same edge commit at the next edge.
- FIFO push and pop in the same cycle leave occupancy unchanged; full FIFO deasserts its ready combinationally from registered occupancy.
- Reset asserted mid-burst: pending writes and in-flight reads are discarded; no app_rd_data_valid after reset release until new reads are accepted.

## Configuration
- MIG_RESP_BACKPRESSURE_EN defined: 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) advances every cycle after calibration; app_rdy additionally forced 0 when lfsr[1:0]==2'b00, app_wdf_rdy forced 0 when lfsr[3:2]==2'b00.
- Undefined: no LFSR; readies depend only on calibration, FIFO and ordering conditions.

## Test plan
- Reset, CALIB_CYCLES=16 -> init_calib_complete rises 16 cycles after rst release; app_rdy/app_wdf_rdy 0 before.
- Write 128'h0123...CDEF to app_addr 0x40, then read 0x40 -> one app_rd_data_valid RD_LATENCY cycles after read acceptance, data matches.
- Write with mask 16'hFFFE over word 0x00 holding all-ones, data all-zeros -> readback 128'hFFFF...FF00.
- 8-beat write burst (addresses 0..0x38, data lags command by 1 cycle) then 8-beat read burst -> 8 valid strobes on consecutive cycles, data in order; read to 0x2000 (MEM_DEPTH_LOG2=10) returns word 0.
- app_cmd=3'b010 with app_en -> accepted, cmd_err=1 until reset, memory unchanged.
- With MIG_RESP_BACKPRESSURE_EN, full `ddr_controller` write/read of 64 beats -> all data matches, no lost or duplicated strobes.

Source files
------------

// File: rtl/mig_app_responder.sv
// MIG-style app-interface responder backed by on-chip memory with fixed read
// latency, a calibration delay and (MIG_RESP_BACKPRESSURE_EN) LFSR backpressure.
// Ports: clk, rst (async, active-high); command app_addr/app_cmd/app_en/app_rdy;
// write data app_wdf_data/mask/wren/end/rdy; read app_rd_data/_valid;
// status init_calib_complete, cmd_err (sticky illegal command).
module mig_app_responder #(
  parameter int DDR_DATA_WIDTH = 128,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int RD_LATENCY     = 4,
  parameter int CALIB_CYCLES   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DDR_ADDR_WIDTH-1:0]   app_addr,
  input  logic [2:0]                  app_cmd,
  input  logic                        app_en,
  output logic                        app_rdy,
  input  logic [DDR_DATA_WIDTH-1:0]   app_wdf_data,
  input  logic [DDR_DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                        app_wdf_wren,
  input  logic                        app_wdf_end,
  output logic                        app_wdf_rdy,
  output logic [DDR_DATA_WIDTH-1:0]   app_rd_data,
  output logic                        app_rd_data_valid,
  output logic                        init_calib_complete,
  output logic                        cmd_err
);

  localparam int DW = DDR_DATA_WIDTH;
  localparam int MW = DDR_DATA_WIDTH / 8;
  localparam int AW = MEM_DEPTH_LOG2;
  localparam int PL = RD_LATENCY - 1;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  logic [AW-1:0]    idx;
  logic             bp_cmd;
  logic             bp_wdf;
  logic             cmd_acc;
  logic             wr_acc;
  logic             rd_acc;
  logic             ill_acc;
  logic             dat_acc;
  logic             commit;

  logic [15:0]      cal_cnt;

  logic [AW-1:0]    af_mem [4];
  logic [1:0]       af_wp;
  logic [1:0]       af_rp;
  logic [2:0]       af_cnt;

  logic [DW+MW-1:0] df_mem [4];
  logic [1:0]       df_wp;
  logic [1:0]       df_rp;
  logic [2:0]       df_cnt;

  logic [DW-1:0]    mem [1<<AW];
  logic [PL-1:0]    rv;
  logic [DW-1:0]    rd [PL];

  logic [AW-1:0]    cm_idx;
  logic [DW-1:0]    cm_data;
  logic [MW-1:0]    cm_mask;

  logic             unused;
  assign unused = ^{app_addr[DDR_ADDR_WIDTH-1:AW+3],
                    app_addr[2:0], app_wdf_end};

  assign idx = app_addr[AW+2:3];

`ifdef MIG_RESP_BACKPRESSURE_EN
  logic [15:0] lfsr;

  // x^16+x^14+x^13+x^11+1, free-running once calibrated
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (init_calib_complete) begin
      lfsr <= {lfsr[14:0],
               lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign bp_cmd = (lfsr[1:0] != 2'b00);
  assign bp_wdf = (lfsr[3:2] != 2'b00);
`else
  assign bp_cmd = 1'b1;
  assign bp_wdf = 1'b1;
`endif

  // A read waits for every earlier write to commit, keeping RAW ordering.
  assign app_rdy = init_calib_complete & (af_cnt != 3'd4)
                 & ~((app_cmd == CMD_RD) & (af_cnt != 3'd0))
                 & bp_cmd;
  assign app_wdf_rdy = init_calib_complete & (df_cnt != 3'd4) & bp_wdf;

  assign cmd_acc = app_en & app_rdy;
  assign wr_acc  = cmd_acc & (app_cmd == CMD_WR);
  assign rd_acc  = cmd_acc & (app_cmd == CMD_RD);
  assign ill_acc = cmd_acc & (app_cmd != CMD_WR) & (app_cmd != CMD_RD);
  assign dat_acc = app_wdf_wren & app_wdf_rdy;
  assign commit  = (af_cnt != 3'd0) & (df_cnt != 3'd0);

  assign cm_idx  = af_mem[af_rp];
  assign cm_data = df_mem[df_rp][DW+MW-1:MW];
  assign cm_mask = df_mem[df_rp][MW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cal_cnt             <= '0;
      init_calib_complete <= 1'b0;
    end else if (!init_calib_complete) begin
      cal_cnt <= cal_cnt + 16'd1;
      if (cal_cnt == 16'(CALIB_CYCLES - 1)) begin
        init_calib_complete <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      af_wp  <= '0;
      af_rp  <= '0;
      af_cnt <= '0;
      df_wp  <= '0;
      df_rp  <= '0;
      df_cnt <= '0;
    end else begin
      if (wr_acc) af_wp <= af_wp + 2'd1;
      if (dat_acc) df_wp <= df_wp + 2'd1;
      if (commit) begin
        af_rp <= af_rp + 2'd1;
        df_rp <= df_rp + 2'd1;
      end
      af_cnt <= af_cnt + {2'b0, wr_acc} - {2'b0, commit};
      df_cnt <= df_cnt + {2'b0, dat_acc} - {2'b0, commit};
    end
  end

  // Storage without reset: FIFO slots, memory, read data pipe.
  always_ff @(posedge clk) begin
    if (wr_acc) af_mem[af_wp] <= idx;
    if (dat_acc) df_mem[df_wp] <= {app_wdf_data, app_wdf_mask};
    if (commit) begin
      for (int b = 0; b < MW; b++) begin
        if (!cm_mask[b]) mem[cm_idx][b*8 +: 8] <= cm_data[b*8 +: 8];
      end
    end
    rd[0] <= mem[idx];
    for (int i = 1; i < PL; i++) begin
      rd[i] <= rd[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv                <= '0;
      app_rd_data_valid <= 1'b0;
      app_rd_data       <= '0;
      cmd_err           <= 1'b0;
    end else begin
      rv[0] <= rd_acc;
      for (int i = 1; i < PL; i++) begin
        rv[i] <= rv[i-1];
      end
      app_rd_data_valid <= rv[PL-1];
      if (rv[PL-1]) app_rd_data <= rd[PL-1];
      if (ill_acc) cmd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mig_app_responder.sv
// Self-checking bench for mig_app_responder: scoreboard of expected read data
// and acceptance cycles, checked against every app_rd_data_valid strobe.
module tb_mig_app_responder;

  localparam int DW  = 128;
  localparam int MW  = 16;
  localparam int L   = 4;
  localparam int CAL = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [27:0]    app_addr = '0;
  logic [2:0]     app_cmd = '0;
  logic           app_en = 1'b0;
  logic           app_rdy;
  logic [DW-1:0]  app_wdf_data = '0;
  logic [MW-1:0]  app_wdf_mask = '0;
  logic           app_wdf_wren = 1'b0;
  logic           app_wdf_end = 1'b0;
  logic           app_wdf_rdy;
  logic [DW-1:0]  app_rd_data;
  logic           app_rd_data_valid;
  logic           init_calib_complete;
  logic           cmd_err;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;

  logic [DW-1:0] exp_q [$];
  int            lat_q [$];
  logic [DW-1:0] mdl [int];

  mig_app_responder #(
    .DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(28), .MEM_DEPTH_LOG2(10),
    .RD_LATENCY(L), .CALIB_CYCLES(CAL)
  ) dut (
    .clk(clk), .rst(rst),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .init_calib_complete(init_calib_complete), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every strobe must match the oldest outstanding read,
  // both in data and in arriving RD_LATENCY edges after acceptance.
  always @(negedge clk) begin
    if (app_rd_data_valid) begin
      logic [DW-1:0] d;
      int a;
      tot_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL strobe: unexpected valid, data %h, required none",
                 app_rd_data);
      end else begin
        d = exp_q.pop_front();
        a = lat_q.pop_front();
        if (app_rd_data !== d || (cyc - a) !== (L - 1)) begin
          $display("FAIL rd_data: got %h lat %0d, required %h lat %0d",
                   app_rd_data, cyc - a + 1, d, L);
        end else begin
          pass_cnt++;
        end
      end
    end
  end

  function automatic void mdl_write(input logic [27:0] a,
                                    input logic [DW-1:0] d,
                                    input logic [MW-1:0] m);
    int k;
    logic [DW-1:0] w;
    k = int'(a[12:3]);
    w = mdl.exists(k) ? mdl[k] : '0;
    for (int b = 0; b < MW; b++) begin
      if (!m[b]) w[b*8 +: 8] = d[b*8 +: 8];
    end
    mdl[k] = w;
  endfunction

  task automatic do_cmd(input logic [2:0] c, input logic [27:0] a);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    @(negedge clk);
    app_cmd = c;
    app_addr = a;
    app_en = 1'b1;
    forever begin
      #1 got = app_rdy;
      @(posedge clk);
      #1;
      if (got) break;
      n++;
      if (n > 200) begin
        tot_cnt++;
        $display("FAIL cmd_timeout: app_rdy %b, required 1", app_rdy);
        break;
      end
      @(negedge clk);
    end
    if (got && c == 3'b001) begin
      exp_q.push_back(mdl[int'(a[12:3])]);
      lat_q.push_back(cyc);
    end
    app_en = 1'b0;
  endtask

  task automatic do_data(input logic [DW-1:0] d, input logic [MW-1:0] m);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    @(negedge clk);
    app_wdf_data = d;
    app_wdf_mask = m;
    app_wdf_wren = 1'b1;
    app_wdf_end = 1'b1;
    forever begin
      #1 got = app_wdf_rdy;
      @(posedge clk);
      #1;
      if (got) break;
      n++;
      if (n > 200) begin
        tot_cnt++;
        $display("FAIL wdf_timeout: app_wdf_rdy %b, required 1", app_wdf_rdy);
        break;
      end
      @(negedge clk);
    end
    app_wdf_wren = 1'b0;
    app_wdf_end = 1'b0;
  endtask

  task automatic do_write(input logic [27:0] a, input logic [DW-1:0] d,
                          input logic [MW-1:0] m);
    mdl_write(a, d, m);
    fork
      do_cmd(3'b000, a);
      do_data(d, m);
    join
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    tot_cnt++;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d reads outstanding, required 0", exp_q.size());
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tot_cnt++;
    if ({app_rdy, app_wdf_rdy, app_rd_data_valid, init_calib_complete,
         cmd_err, app_rd_data} !== '0) begin
      $display("FAIL reset_vals: rdy %b wrdy %b v %b cal %b err %b d %h, required 0",
               app_rdy, app_wdf_rdy, app_rd_data_valid,
               init_calib_complete, cmd_err, app_rd_data);
    end else pass_cnt++;
    rst = 1'b0;
    for (int k = 1; k <= CAL; k++) begin
      @(negedge clk);
      if (k == CAL - 1) begin
        tot_cnt++;
        if ({init_calib_complete, app_rdy, app_wdf_rdy} !== 3'b000) begin
          $display("FAIL calib_early: cal/rdy/wrdy %b, required 000",
                   {init_calib_complete, app_rdy, app_wdf_rdy});
        end else pass_cnt++;
      end
    end
    tot_cnt++;
    if ({init_calib_complete, app_rdy, app_wdf_rdy} !== 3'b111) begin
      $display("FAIL calib_done: cal/rdy/wrdy %b, required 111",
               {init_calib_complete, app_rdy, app_wdf_rdy});
    end else pass_cnt++;
  endtask

  task automatic test_write_read();
    do_write(28'h40, 128'h0123456789ABCDEF0123456789ABCDEF, '0);
    do_cmd(3'b001, 28'h40);
    wait_drain();
  endtask

  task automatic test_mask();
    do_write(28'h0, {DW{1'b1}}, '0);
    do_write(28'h0, '0, 16'hFFFE);
    tot_cnt++;
    if (mdl[0] !== {{120{1'b1}}, 8'h00}) begin
      $display("FAIL mask_model: %h, required FF..FF00", mdl[0]);
    end else pass_cnt++;
    do_cmd(3'b001, 28'h0);
    wait_drain();
  endtask

  task automatic test_burst();
    logic [DW-1:0] bd [8];
    for (int i = 0; i < 8; i++) begin
      bd[i] = {4{32'(i) * 32'h1111_1111 ^ 32'hA5A5_0000}};
      mdl_write(28'(i * 8), bd[i], '0);
    end
    fork
      for (int i = 0; i < 8; i++) do_cmd(3'b000, 28'(i * 8));
      begin
        @(posedge clk);
        for (int j = 0; j < 8; j++) do_data(bd[j], '0);
      end
    join
    for (int i = 0; i < 8; i++) do_cmd(3'b001, 28'(i * 8));
    do_cmd(3'b001, 28'h2000);
    wait_drain();
  endtask

  task automatic test_data_first();
    logic [DW-1:0] bd [4];
    for (int i = 0; i < 4; i++) begin
      bd[i] = {4{32'hC0DE_0000 + 32'(i)}};
      do_data(bd[i], '0);
    end
    @(negedge clk);
    #1;
    tot_cnt++;
    if (app_wdf_rdy !== 1'b0) begin
      $display("FAIL wdf_full: app_wdf_rdy %b, required 0", app_wdf_rdy);
    end else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      mdl_write(28'h100 + 28'(i * 8), bd[i], '0);
      do_cmd(3'b000, 28'h100 + 28'(i * 8));
    end
    for (int i = 0; i < 4; i++) do_cmd(3'b001, 28'h100 + 28'(i * 8));
    wait_drain();
  endtask

  task automatic test_illegal();
    do_cmd(3'b010, 28'h40);
    @(negedge clk);
    tot_cnt++;
    if (cmd_err !== 1'b1) begin
      $display("FAIL cmd_err_set: %b, required 1", cmd_err);
    end else pass_cnt++;
    do_cmd(3'b001, 28'h40);
    wait_drain();
    tot_cnt++;
    if (cmd_err !== 1'b1) begin
      $display("FAIL cmd_err_sticky: %b, required 1", cmd_err);
    end else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int n;
    do_cmd(3'b001, 28'h40);
    do_cmd(3'b001, 28'h0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    #1;
    tot_cnt++;
    if ({app_rd_data_valid, init_calib_complete, cmd_err, app_rdy} !== 4'b0) begin
      $display("FAIL mid_reset: v/cal/err/rdy %b, required 0000",
               {app_rd_data_valid, init_calib_complete, cmd_err, app_rdy});
    end else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!init_calib_complete && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    tot_cnt++;
    if (init_calib_complete !== 1'b1 || n !== CAL) begin
      $display("FAIL recalib: cal %b after %0d cycles, required 1 after %0d",
               init_calib_complete, n, CAL);
    end else pass_cnt++;
    do_cmd(3'b001, 28'h40);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_mask();
    test_burst();
    test_data_first();
    test_illegal();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
